// File: rtl/bluetooth_uart_link.sv
// UART endpoint of a Bluetooth-module link: sends a short fixed message framed 8N1 on tx
// and reports every well-framed byte received on rx. The transmitter and receiver run independently.
module bluetooth_uart_link #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [63:0] MSG          = {"Z", "Z", "Z", "Z", "Z", "C", "B", "A"},
  parameter logic [7:0]  MSG_VALID    = 8'b0000_0111
) (
  input  logic       clk,
  input  logic       reset,
  output logic       tx,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic [3:0] rx_count,
  output logic       tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SCAN,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_DONE
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_RECOVER
  } rx_state_t;

  logic [7:0] msg_table [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_msg
    assign msg_table[gi] = MSG[8*gi +: 8];
  end

  // ---------------------------------------------------------------- transmitter
  tx_state_t        tx_state_q;
  logic [3:0]       tx_idx_q;
  logic [3:0]       tx_idx_d;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [2:0]       tx_bit_q;
  logic [7:0]       tx_shift_q;
  logic             tx_q;
  logic             tx_done_q;
  logic             tx_bit_end;

  assign tx_idx_d   = tx_idx_q + 4'd1;
  assign tx_bit_end = (tx_cnt_q == BIT_LAST);

  // tx is registered: it changes on the edge that enters a state, so every state
  // holds the line for exactly CLKS_PER_BIT cycles and SCAN contributes one idle cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_idx_q   <= 4'd0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_q       <= 1'b1;
          tx_state_q <= TX_SCAN;
        end
        TX_SCAN: begin
          if (tx_idx_q[3]) begin
            tx_done_q  <= 1'b1;
            tx_state_q <= TX_DONE;
          end else if (!MSG_VALID[tx_idx_q[2:0]]) begin
            tx_idx_q <= tx_idx_d;
          end else begin
            tx_shift_q <= msg_table[tx_idx_q[2:0]];
            tx_cnt_q   <= '0;
            tx_q       <= 1'b0;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_q       <= tx_shift_q[0];
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_ONE;
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_q       <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_q       <= tx_shift_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_ONE;
          end
        end
        TX_STOP: begin
          if (tx_bit_end) begin
            tx_cnt_q   <= '0;
            tx_idx_q   <= tx_idx_d;
            tx_state_q <= TX_SCAN;
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_ONE;
          end
        end
        TX_DONE: begin
          tx_q      <= 1'b1;
          tx_done_q <= 1'b1;
        end
        default: begin
          tx_q       <= 1'b1;
          tx_state_q <= TX_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- receiver
  rx_state_t        rx_state_q;
  logic             rx_meta_q;
  logic             rx_sync_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0]       rx_bit_q;
  logic [7:0]       rx_shift_q;
  logic [7:0]       rx_byte_q;
  logic             rx_valid_q;
  logic             frame_err_q;
  logic [3:0]       rx_count_q;
  logic [3:0]       rx_count_d;
  logic             rx_bit_end;

  assign rx_count_d = (rx_count_q == 4'd15) ? 4'd15 : rx_count_q + 4'd1;
  assign rx_bit_end = (rx_cnt_q == BIT_LAST);

  // Synchronizer presets to idle-high so a reset release never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'h00;
      rx_byte_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_count_q  <= 4'd0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_sync_q) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          // Recheck at mid start bit; a line already back high was a glitch.
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q <= '0;
            rx_bit_q <= 3'd0;
            if (rx_sync_q) begin
              rx_state_q <= RX_IDLE;
            end else begin
              rx_state_q <= RX_DATA;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (rx_bit_end) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 3'd1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (rx_bit_end) begin
            rx_cnt_q <= '0;
            if (rx_sync_q) begin
              rx_byte_q  <= rx_shift_q;
              rx_valid_q <= 1'b1;
              rx_count_q <= rx_count_d;
              rx_state_q <= RX_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              rx_state_q  <= RX_RECOVER;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_ONE;
          end
        end
        RX_RECOVER: begin
          if (rx_sync_q) begin
            rx_state_q <= RX_IDLE;
          end
        end
        default: begin
          rx_state_q <= RX_IDLE;
        end
      endcase
    end
  end

  assign tx        = tx_q;
  assign tx_done   = tx_done_q;
  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign rx_count  = rx_count_q;

endmodule

// File: tb/tb_bluetooth_uart_link.sv
// Bench for bluetooth_uart_link: a cross-connected pair for the message link, plus two
// silent-transmitter instances whose rx lines are driven by a frame model.
module tb_bluetooth_uart_link;

  localparam int CPB   = 434;
  localparam int CPB_D = 16;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_ab = 1'b0;
  logic rst_c  = 1'b0;
  logic rst_d  = 1'b0;
  logic rx_c   = 1'b1;
  logic rx_d   = 1'b1;

  logic       tx_a, tx_b, tx_c, tx_d;
  logic [7:0] rx_byte_a, rx_byte_b, rx_byte_c, rx_byte_d;
  logic       rx_valid_a, rx_valid_b, rx_valid_c, rx_valid_d;
  logic       frame_err_a, frame_err_b, frame_err_c, frame_err_d;
  logic [3:0] rx_count_a, rx_count_b, rx_count_c, rx_count_d;
  logic       tx_done_a, tx_done_b, tx_done_c, tx_done_d;

  bluetooth_uart_link u_a (
    .clk(clk), .reset(rst_ab), .tx(tx_a), .rx(tx_b), .rx_byte(rx_byte_a), .rx_valid(rx_valid_a),
    .frame_err(frame_err_a), .rx_count(rx_count_a), .tx_done(tx_done_a)
  );
  bluetooth_uart_link u_b (
    .clk(clk), .reset(rst_ab), .tx(tx_b), .rx(tx_a), .rx_byte(rx_byte_b), .rx_valid(rx_valid_b),
    .frame_err(frame_err_b), .rx_count(rx_count_b), .tx_done(tx_done_b)
  );
  bluetooth_uart_link #(.MSG_VALID(8'h00)) u_c (
    .clk(clk), .reset(rst_c), .tx(tx_c), .rx(rx_c), .rx_byte(rx_byte_c), .rx_valid(rx_valid_c),
    .frame_err(frame_err_c), .rx_count(rx_count_c), .tx_done(tx_done_c)
  );
  bluetooth_uart_link #(.CLKS_PER_BIT(CPB_D), .MSG_VALID(8'h00)) u_d (
    .clk(clk), .reset(rst_d), .tx(tx_d), .rx(rx_d), .rx_byte(rx_byte_d), .rx_valid(rx_valid_d),
    .frame_err(frame_err_d), .rx_count(rx_count_d), .tx_done(tx_done_d)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event scoreboard, sampled mid-cycle.
  logic [7:0] a_q[$];
  logic [7:0] b_q[$];
  int a_ferr = 0, b_ferr = 0, c_valid = 0, c_ferr = 0, d_valid = 0, overlap = 0;

  always @(negedge clk) begin
    if (rx_valid_a === 1'b1) a_q.push_back(rx_byte_a);
    if (rx_valid_b === 1'b1) b_q.push_back(rx_byte_b);
    if (frame_err_a === 1'b1) a_ferr <= a_ferr + 1;
    if (frame_err_b === 1'b1) b_ferr <= b_ferr + 1;
    if (rx_valid_c === 1'b1) c_valid <= c_valid + 1;
    if (frame_err_c === 1'b1) c_ferr <= c_ferr + 1;
    if (rx_valid_d === 1'b1) d_valid <= d_valid + 1;
    if ((rx_valid_a && frame_err_a) || (rx_valid_b && frame_err_b) ||
        (rx_valid_c && frame_err_c) || (rx_valid_d && frame_err_d))
      overlap <= overlap + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rx(input bit to_d, input logic v);
    if (to_d) rx_d = v;
    else      rx_c = v;
  endtask

  // Drives one 8N1 frame; lat reports how many cycles after the stop-bit midpoint rx_valid appeared.
  task automatic drive_frame(input bit to_d, input int cpb, input logic [7:0] b,
                             input logic stop_bit, output int lat);
    set_rx(to_d, 1'b0);
    tick(cpb);
    for (int i = 0; i < 8; i++) begin
      set_rx(to_d, b[i]);
      tick(cpb);
    end
    set_rx(to_d, stop_bit);
    tick(cpb / 2);
    lat = -1;
    for (int k = 1; k <= cpb - cpb / 2; k++) begin
      tick(1);
      if (lat < 0 && ((to_d ? rx_valid_d : rx_valid_c) === 1'b1)) lat = k;
    end
    set_rx(to_d, 1'b1);
    tick(cpb);
  endtask

  task automatic test_reset();
    rst_ab = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    tick(3);
    checks++;
    if ({tx_a, rx_byte_a, rx_valid_a, frame_err_a, rx_count_a, tx_done_a} !== 16'h8000) begin
      errors++;
      $display("FAIL reset_a got tx=%b byte=%h v=%b fe=%b cnt=%0d done=%b exp tx=1 rest 0",
               tx_a, rx_byte_a, rx_valid_a, frame_err_a, rx_count_a, tx_done_a);
    end
    checks++;
    if ({tx_c, rx_byte_c, rx_valid_c, frame_err_c, rx_count_c, tx_done_c} !== 16'h8000) begin
      errors++;
      $display("FAIL reset_c got tx=%b byte=%h v=%b fe=%b cnt=%0d done=%b exp tx=1 rest 0",
               tx_c, rx_byte_c, rx_valid_c, frame_err_c, rx_count_c, tx_done_c);
    end
    $display("test_reset done");
  endtask

  task automatic check_runs(input string tag, input int nruns, input int exp_len[7]);
    logic lvl;
    int   len;
    lvl = 1'b0;
    for (int i = 0; i < nruns; i++) begin
      len = 0;
      while (tx_a === lvl && len < 5000) begin
        tick(1);
        len++;
      end
      checks++;
      if (len != exp_len[i]) begin
        errors++;
        $display("FAIL %s_run%0d level=%b got %0d cycles exp %0d", tag, i, lvl, len, exp_len[i]);
      end
      lvl = ~lvl;
    end
  endtask

  task automatic wait_first_start(input string tag);
    int n;
    n = 0;
    while (tx_a !== 1'b0 && n < 20) begin
      tick(1);
      n++;
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL %s_start_latency got %0d cycles exp 2", tag, n);
    end
  endtask

  task automatic test_loopback();
    int exp_len[7];
    int rel;
    exp_len = '{434, 434, 2170, 434, 434, 435, 868};
    rst_ab = 1'b1;
    rel = cyc;
    wait_first_start("loop");
    check_runs("loop", 7, exp_len);
    while (!(tx_done_a === 1'b1 && tx_done_b === 1'b1) && (cyc - rel) < 3 * (10 * CPB + 1) + 10)
      tick(1);
    checks++;
    if (!(tx_done_a === 1'b1 && tx_done_b === 1'b1)) begin
      errors++;
      $display("FAIL tx_done got a=%b b=%b after %0d cycles exp both 1", tx_done_a, tx_done_b, cyc - rel);
    end
    tick(50);
    checks++;
    if (a_q.size() != 3 || b_q.size() != 3) begin
      errors++;
      $display("FAIL rx_pulses got a=%0d b=%0d exp 3 each", a_q.size(), b_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      logic [7:0] ga, gb, ex;
      ga = (i < a_q.size()) ? a_q[i] : 8'hxx;
      gb = (i < b_q.size()) ? b_q[i] : 8'hxx;
      ex = 8'h41 + 8'(i);
      checks++;
      if (ga !== ex || gb !== ex) begin
        errors++;
        $display("FAIL rx_byte%0d got a=%h b=%h exp %h", i, ga, gb, ex);
      end
    end
    checks++;
    if (rx_count_a !== 4'd3 || rx_count_b !== 4'd3) begin
      errors++;
      $display("FAIL rx_count_loop got a=%0d b=%0d exp 3", rx_count_a, rx_count_b);
    end
    checks++;
    if (a_ferr != 0 || b_ferr != 0) begin
      errors++;
      $display("FAIL frame_err_loop got a=%0d b=%0d exp 0", a_ferr, b_ferr);
    end
    $display("test_loopback done");
  endtask

  task automatic test_mid_reset();
    int exp_len[7];
    exp_len = '{434, 434, 2170, 0, 0, 0, 0};
    rst_ab = 1'b0;
    tick(3);
    rst_ab = 1'b1;
    wait_first_start("pre_reset");
    // Middle of bit 0 of the 0x42 frame, which is a 0.
    tick((10 * CPB + 1) + CPB + CPB / 2);
    checks++;
    if (tx_a !== 1'b0 || rx_count_a !== 4'd1) begin
      errors++;
      $display("FAIL mid_frame got tx=%b cnt=%0d exp tx=0 cnt=1", tx_a, rx_count_a);
    end
    rst_ab = 1'b0;
    tick(1);
    checks++;
    if (tx_a !== 1'b1 || tx_done_a !== 1'b0 || rx_count_a !== 4'd0) begin
      errors++;
      $display("FAIL abort got tx=%b done=%b cnt=%0d exp tx=1 done=0 cnt=0", tx_a, tx_done_a, rx_count_a);
    end
    tick(2);
    rst_ab = 1'b1;
    wait_first_start("restart");
    check_runs("restart", 3, exp_len);
    $display("test_mid_reset done");
  endtask

  task automatic test_msg_valid_zero();
    int n, bad;
    n = 0;
    bad = 0;
    rst_c = 1'b1;
    while (tx_done_c !== 1'b1 && n < 40) begin
      tick(1);
      n++;
      if (tx_c !== 1'b1) bad++;
    end
    checks++;
    if (tx_done_c !== 1'b1 || n < 9 || n > 10) begin
      errors++;
      $display("FAIL empty_msg_done got done=%b after %0d cycles exp 1 after 9-10", tx_done_c, n);
    end
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (tx_c !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL empty_msg_tx got %0d low cycles exp 0", bad);
    end
    $display("test_msg_valid_zero done");
  endtask

  task automatic test_rx_errors();
    int lat;
    rx_c = 1'b0;
    tick(100);
    rx_c = 1'b1;
    tick(600);
    checks++;
    if (c_valid != 0 || c_ferr != 0 || rx_count_c !== 4'd0) begin
      errors++;
      $display("FAIL glitch got valid=%0d ferr=%0d cnt=%0d exp 0 0 0", c_valid, c_ferr, rx_count_c);
    end
    drive_frame(1'b0, CPB, 8'h5A, 1'b0, lat);
    checks++;
    if (c_ferr != 1 || c_valid != 0) begin
      errors++;
      $display("FAIL bad_stop_pulses got ferr=%0d valid=%0d exp 1 0", c_ferr, c_valid);
    end
    checks++;
    if (rx_count_c !== 4'd0 || rx_byte_c !== 8'h00) begin
      errors++;
      $display("FAIL bad_stop_hold got cnt=%0d byte=%h exp 0 00", rx_count_c, rx_byte_c);
    end
    drive_frame(1'b0, CPB, 8'hA5, 1'b1, lat);
    checks++;
    if (c_valid != 1 || rx_byte_c !== 8'hA5 || rx_count_c !== 4'd1) begin
      errors++;
      $display("FAIL good_after_err got valid=%0d byte=%h cnt=%0d exp 1 a5 1", c_valid, rx_byte_c, rx_count_c);
    end
    checks++;
    if (lat < 1 || lat > 3) begin
      errors++;
      $display("FAIL rx_latency got %0d cycles exp 1-3", lat);
    end
    $display("test_rx_errors done");
  endtask

  task automatic test_saturation();
    int lat;
    logic [7:0] b;
    rst_d = 1'b1;
    tick(5);
    b = 8'h00;
    for (int i = 0; i < 16; i++) begin
      b = 8'(i * 37 + 5);
      drive_frame(1'b1, CPB_D, b, 1'b1, lat);
      if (i == 14) begin
        checks++;
        if (rx_count_d !== 4'd15) begin
          errors++;
          $display("FAIL count_15 got %0d exp 15", rx_count_d);
        end
      end
    end
    checks++;
    if (rx_count_d !== 4'd15 || d_valid != 16 || rx_byte_d !== b) begin
      errors++;
      $display("FAIL saturate got cnt=%0d pulses=%0d byte=%h exp 15 16 %h", rx_count_d, d_valid, rx_byte_d, b);
    end
    $display("test_saturation done");
  endtask

  task automatic test_no_overlap();
    checks++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL valid_err_overlap got %0d cycles exp 0", overlap);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_mid_reset();
    test_msg_valid_zero();
    test_rx_errors();
    test_saturation();
    test_no_overlap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bluetooth_uart_link.md
Name: bluetooth_uart_link

Overview:
- Serial link endpoint modelling a Bluetooth-module UART. After reset it sends a fixed message of up to 8 characters from a parameter table, framed 8N1, on tx.
- At the same time it receives 8N1 frames on rx and reports each good byte on status outputs.
- Two instances are cross-connected (tx of one to rx of the other) to form a loopback link at system level.

Parameters:
- CLKS_PER_BIT, 434: clock cycles per bit (50 MHz / 115200 baud). Must be >= 4.
- MSG, {"Z","Z","Z","Z","Z","C","B","A"} (64 bits): character table. Entry i is MSG[8i+7:8i]; entry 0 is sent first.
- MSG_VALID, 8'b0000_0111: entry i is sent only when bit i is 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- tx  out  1  serial transmit line; idles high.
- rx  in  1  serial receive line; asynchronous to the bit grid.
- rx_byte  out  8  last correctly received byte.
- rx_valid  out  1  one-cycle pulse when rx_byte updates.
- frame_err  out  1  one-cycle pulse on a bad stop bit.
- rx_count  out  4  good bytes received, saturates at 15.
- tx_done  out  1  high once the message is fully sent.

Behaviour:
- Reset (reset==0 sampled at a rising clk edge):
  - tx=1, rx_byte=0, rx_valid=0, frame_err=0, rx_count=0, tx_done=0.
  - TX index=0; both FSMs go to IDLE; rx synchronizer flops preset to 1.
  - Reset mid-frame aborts immediately: tx is 1 from the next edge, and the message restarts from entry 0 after release.
- TX FSM states: IDLE, SCAN, START, DATA, STOP, DONE.
  - IDLE: the first edge with reset high moves to SCAN.
  - SCAN (one cycle per entry examined):
    - index==8: go to DONE.
    - MSG_VALID[index]==0: index++, stay in SCAN.
    - Otherwise: latch the byte and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then index++ and go to SCAN.
  - DONE: tx=1 and tx_done=1 held until reset.
  - Frame length: exactly 10*CLKS_PER_BIT cycles. Gap between frames of consecutive valid entries: 1 cycle of tx=1 (the SCAN cycle).
- RX:
  - Input path: 2-flop synchronizer, then FSM with states IDLE, START, DATA, STOP, RECOVER.
  - IDLE: a synchronized 0 enters START with the counter cleared.
  - START: at CLKS_PER_BIT/2 (integer division) cycles, sample the line.
    - 1: false start, return to IDLE with no output.
    - 0: go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles (mid-bit), shifting LSB first, 8 bits.
  - STOP: sample after a further CLKS_PER_BIT cycles.
    - 1: rx_byte=data, rx_valid=1 for one cycle, rx_count++ (saturate at 15), go to IDLE.
    - 0: frame_err=1 for one cycle, rx_byte and rx_count unchanged, go to RECOVER.
  - RECOVER: wait for a synchronized 1, then go to IDLE.
- TX and RX operate fully independently; simultaneous send and receive is required.
- rx_valid and frame_err never assert in the same cycle.
- Latency from the rx stop-bit midpoint to the rx_valid pulse: 3 cycles max, including the synchronizer.

Test Plan:
- Two instances cross-connected, defaults, CLKS_PER_BIT=434, 50 MHz clock, reset low 20 ns then high:
  - Each instance gets rx_valid pulses with rx_byte 0x41, 0x42, 0x43, in order.
  - rx_count=3; frame_err never asserts.
  - tx_done=1 within 3*(10*434+1)+10 cycles of reset release.
- Single instance, tx monitored:
  - First start bit is exactly 434 cycles low.
  - 0x41 appears LSB first as 1,0,0,0,0,0,1,0, then a 434-cycle stop bit.
  - Frames are separated by a 1-cycle gap.
- MSG_VALID=8'h00: tx stays 1 throughout; tx_done rises 9–10 cycles after reset release.
- rx driven by a model:
  - 100-cycle low glitch: no rx_valid, no frame_err.
  - Byte 0x5A with stop bit 0: frame_err pulse; rx_count unchanged.
  - A following valid 0xA5: rx_byte=0xA5, rx_count increments.
- Reset asserted mid-DATA of the second frame:
  - tx=1 the next cycle; tx_done=0; rx_count=0.
  - After release, transmission restarts with 0x41.
- 16 valid bytes received: rx_count saturates at 15.
